// File: rtl/filter2d_mem_host.sv
// filter2d_mem_host: host sequencer and image-RAM responder for the filter2d engine.
// Loads coefficients and the input image from a byte stream into bank 0. Starts the engine
// and serves its memory accesses. Afterwards it streams bank 1 out through a 2-entry FIFO.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | waiting for go; nothing owns the RAM
//   S_COEF  | accepting NCOEF coefficient bytes, forwarded on h_*
//   S_LOAD  | accepting IMG_W*IMG_H pixel bytes into bank 0
//   S_START | one-cycle f_start pulse to the engine
//   S_RUN   | engine owns the RAM until f_finish
//   S_DRAIN | bank 1 read out through the FIFO onto m_*
//   S_DONE  | one-cycle done pulse, then back to idle
module filter2d_mem_host #(
   parameter int IMG_W = 256,
   parameter int IMG_H = 256,
   parameter int AW    = 17,
   parameter int NCOEF = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          go,
   output logic          busy,
   output logic          done,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [7:0]    s_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [7:0]    m_data,
   output logic          m_last,
   output logic          f_start,
   input  logic          f_finish,
   input  logic          f_cs,
   input  logic          f_we,
   input  logic [AW-1:0] f_addr,
   input  logic [7:0]    f_wdata,
   output logic [7:0]    f_rdata,
   output logic          h_write,
   output logic [3:0]    h_idx,
   output logic [7:0]    h_data
);

   localparam int NPIX  = IMG_W * IMG_H;
   localparam int DEPTH = 2 * NPIX;
   localparam int CW    = $clog2(NPIX);

   localparam logic [AW-1:0] BANK1     = AW'(NPIX);
   localparam logic [3:0]    LAST_COEF = 4'(NCOEF - 1);
   localparam logic [CW-1:0] LAST_PIX  = CW'(NPIX - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_COEF  = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_START = 3'd3;
   localparam logic [2:0] S_RUN   = 3'd4;
   localparam logic [2:0] S_DRAIN = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   logic [2:0]    state_q, state_d;
   logic [3:0]    coef_cnt_q, coef_cnt_d;
   logic [CW-1:0] pix_cnt_q, pix_cnt_d;
   logic [CW-1:0] rd_cnt_q, rd_cnt_d;
   logic          rd_done_q, rd_done_d;
   logic [CW-1:0] out_cnt_q, out_cnt_d;

   logic [7:0]    mem [0:DEPTH-1];
   logic [7:0]    dr_q;
   logic          inflight_q;
   logic [7:0]    fifo_q [2];
   logic          wr_ptr_q, rd_ptr_q;
   logic [1:0]    occ_q;
   logic [7:0]    f_rdata_q;

   logic          s_hs, m_hs, issue, load_wr, eng_wr, eng_rd;
   logic [2:0]    lvl;

   assign s_ready = (state_q == S_COEF) || (state_q == S_LOAD);
   assign s_hs    = s_valid & s_ready;
   assign m_valid = (occ_q != 2'd0);
   assign m_hs    = m_valid & m_ready;

   // Slots already claimed once this cycle's pop is counted; keeps 1 byte/cycle at full rate.
   assign lvl     = {1'b0, occ_q} - {2'b0, m_hs} + {2'b0, inflight_q};
   assign issue   = (state_q == S_DRAIN) && !rd_done_q && (lvl < 3'd2);

   assign load_wr = (state_q == S_LOAD) && s_valid;
   assign eng_wr  = (state_q == S_RUN) && f_cs && f_we;
   assign eng_rd  = (state_q == S_RUN) && f_cs && !f_we;

   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE);
   assign f_start = (state_q == S_START);
   assign f_rdata = f_rdata_q;
   assign h_write = (state_q == S_COEF) && s_valid;
   assign h_idx   = (state_q == S_COEF) ? coef_cnt_q : 4'd0;
   assign h_data  = h_write ? s_data : 8'd0;
   assign m_data  = m_valid ? fifo_q[rd_ptr_q] : 8'd0;
   assign m_last  = m_valid && (out_cnt_q == LAST_PIX);

   // Sequencing and job counters; counters stop at their terminal values.
   always_comb begin
      state_d    = state_q;
      coef_cnt_d = coef_cnt_q;
      pix_cnt_d  = pix_cnt_q;
      rd_cnt_d   = rd_cnt_q;
      rd_done_d  = rd_done_q;
      out_cnt_d  = out_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (go) begin
               state_d    = S_COEF;
               coef_cnt_d = '0;
               pix_cnt_d  = '0;
               rd_cnt_d   = '0;
               rd_done_d  = 1'b0;
               out_cnt_d  = '0;
            end
         end
         S_COEF: begin
            if (s_hs) begin
               if (coef_cnt_q == LAST_COEF) state_d = S_LOAD;
               else                         coef_cnt_d = coef_cnt_q + 4'd1;
            end
         end
         S_LOAD: begin
            if (s_hs) begin
               if (pix_cnt_q == LAST_PIX) state_d = S_START;
               else                       pix_cnt_d = pix_cnt_q + 1'b1;
            end
         end
         S_START: state_d = S_RUN;
         S_RUN: begin
            if (f_finish) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (issue) begin
               if (rd_cnt_q == LAST_PIX) rd_done_d = 1'b1;
               else                      rd_cnt_d  = rd_cnt_q + 1'b1;
            end
            if (m_hs) begin
               if (out_cnt_q == LAST_PIX) state_d = S_DONE;
               else                       out_cnt_d = out_cnt_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         coef_cnt_q <= '0;
         pix_cnt_q  <= '0;
         rd_cnt_q   <= '0;
         rd_done_q  <= 1'b0;
         out_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         coef_cnt_q <= coef_cnt_d;
         pix_cnt_q  <= pix_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         rd_done_q  <= rd_done_d;
         out_cnt_q  <= out_cnt_d;
      end
   end

   // Single-port RAM: only one owner is active in any state, so the accesses never collide.
   always_ff @(posedge clk) begin
      if (load_wr)     mem[AW'(pix_cnt_q)] <= s_data;
      else if (eng_wr) mem[f_addr]         <= f_wdata;
      if (issue)       dr_q                <= mem[BANK1 + AW'(rd_cnt_q)];
   end

   // Engine read data: registered, held between reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         f_rdata_q <= '0;
      else if (eng_rd) f_rdata_q <= mem[f_addr];
   end

   // Output FIFO: a read issued last cycle lands here; the head is popped on the m_* handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_q <= 1'b0;
         fifo_q[0]  <= '0;
         fifo_q[1]  <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         occ_q      <= '0;
      end else begin
         inflight_q <= issue;
         if (inflight_q) begin
            fifo_q[wr_ptr_q] <= dr_q;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (m_hs) rd_ptr_q <= ~rd_ptr_q;
         occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, m_hs};
      end
   end

endmodule

// File: tb/tb_filter2d_mem_host.sv
// Directed bench for filter2d_mem_host on a small 8x4 image; the bench plays host and engine.
module tb_filter2d_mem_host;

   localparam int IMG_W = 8;
   localparam int IMG_H = 4;
   localparam int AW    = 6;
   localparam int NCOEF = 9;
   localparam int N     = IMG_W * IMG_H;

   logic          clk = 1'b0;
   logic          rst;
   logic          go, busy, done;
   logic          s_valid, s_ready;
   logic [7:0]    s_data;
   logic          m_valid, m_ready, m_last;
   logic [7:0]    m_data;
   logic          f_start, f_finish, f_cs, f_we;
   logic [AW-1:0] f_addr;
   logic [7:0]    f_wdata, f_rdata;
   logic          h_write;
   logic [3:0]    h_idx;
   logic [7:0]    h_data;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_out [N];
   logic [7:0] coefs [NCOEF] = '{8'h08, 8'h10, 8'h08, 8'h10, 8'h20, 8'h10, 8'h08, 8'h10, 8'h08};

   always #5 clk = ~clk;

   filter2d_mem_host #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .NCOEF(NCOEF)) dut (
      .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .f_start(f_start), .f_finish(f_finish), .f_cs(f_cs), .f_we(f_we),
      .f_addr(f_addr), .f_wdata(f_wdata), .f_rdata(f_rdata),
      .h_write(h_write), .h_idx(h_idx), .h_data(h_data)
   );

   function automatic logic [7:0] pix_val(input int k, input int seed);
      return 8'(k * seed + 3);
   endfunction

   // Stand-in engine result: inverted input pixel.
   function automatic logic [7:0] eng_val(input int k, input int seed);
      return pix_val(k, seed) ^ 8'hFF;
   endfunction

   task automatic do_go();
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic send_coefs();
      for (int i = 0; i < NCOEF; i++) begin
         s_valid = 1'b1;
         s_data  = coefs[i];
         @(negedge clk);
      end
      s_valid = 1'b0;
   endtask

   task automatic send_pixels(input int count, input int seed);
      for (int k = 0; k < count; k++) begin
         s_valid = 1'b1;
         s_data  = pix_val(k, seed);
         @(negedge clk);
      end
      s_valid = 1'b0;
   endtask

   task automatic engine_fill(input int seed);
      for (int k = 0; k < N; k++) begin
         f_cs       = 1'b1;
         f_we       = 1'b1;
         f_addr     = AW'(N + k);
         f_wdata    = eng_val(k, seed);
         exp_out[k] = eng_val(k, seed);
         @(negedge clk);
      end
      f_cs = 1'b0;
      f_we = 1'b0;
   endtask

   task automatic finish_pulse();
      f_finish = 1'b1;
      @(negedge clk);
      f_finish = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; go = 0; s_valid = 0; s_data = 0; m_ready = 0;
      f_finish = 0; f_cs = 0; f_we = 0; f_addr = 0; f_wdata = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #1;
      checks++; if ({busy, done, s_ready, m_valid, m_last, f_start, h_write} !== 7'b0) begin
         errors++; $display("FAIL reset_ctrl got %b want 0000000", {busy, done, s_ready, m_valid, m_last, f_start, h_write}); end
      checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got %h want 00", m_data); end
      checks++; if (f_rdata !== 8'h00) begin errors++; $display("FAIL reset_f_rdata got %h want 00", f_rdata); end
      checks++; if ({h_idx, h_data} !== 12'h000) begin errors++; $display("FAIL reset_h got %h want 000", {h_idx, h_data}); end
      s_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if ({busy, s_ready} !== 2'b00) begin errors++; $display("FAIL idle_ready got %b want 00", {busy, s_ready}); end
         @(negedge clk);
      end
      s_valid = 1'b0;
   endtask

   task automatic test_coeffs();
      do_go();
      #1;
      checks++; if ({busy, s_ready} !== 2'b11) begin errors++; $display("FAIL coef_entry got %b want 11", {busy, s_ready}); end
      for (int i = 0; i < NCOEF; i++) begin
         if (i == 4) begin
            s_valid = 1'b0;
            #1;
            checks++; if (h_write !== 1'b0) begin errors++; $display("FAIL coef_gap h_write got %b want 0", h_write); end
            @(negedge clk);
         end
         s_valid = 1'b1;
         s_data  = coefs[i];
         #1;
         checks++; if (h_write !== 1'b1) begin errors++; $display("FAIL coef_write[%0d] got %b want 1", i, h_write); end
         checks++; if (h_idx !== 4'(i)) begin errors++; $display("FAIL coef_idx[%0d] got %0d want %0d", i, h_idx, i); end
         checks++; if (h_data !== coefs[i]) begin errors++; $display("FAIL coef_data[%0d] got %h want %h", i, h_data, coefs[i]); end
         @(negedge clk);
      end
      s_valid = 1'b0;
      #1;
      checks++; if ({h_write, s_ready, busy} !== 3'b011) begin errors++; $display("FAIL coef_to_load got %b want 011", {h_write, s_ready, busy}); end
   endtask

   task automatic test_load(input int seed);
      send_pixels(N, seed);
      #1;
      checks++; if ({f_start, s_ready, busy} !== 3'b101) begin errors++; $display("FAIL start_pulse got %b want 101", {f_start, s_ready, busy}); end
      @(negedge clk); #1;
      checks++; if ({f_start, s_ready, busy} !== 3'b001) begin errors++; $display("FAIL start_end got %b want 001", {f_start, s_ready, busy}); end
   endtask

   task automatic test_run_ram(input int seed);
      go = 1'b1; s_valid = 1'b1; s_data = 8'hEE;
      #1;
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL run_s_ready got %b want 0", s_ready); end
      @(negedge clk);
      go = 1'b0; s_valid = 1'b0;
      #1;
      checks++; if ({busy, f_start} !== 2'b10) begin errors++; $display("FAIL run_go_ignored got %b want 10", {busy, f_start}); end
      f_cs = 1'b1; f_we = 1'b1; f_addr = 6'd40; f_wdata = 8'h5A;
      @(negedge clk);
      f_we = 1'b0;
      #1;
      checks++; if (f_rdata !== 8'h00) begin errors++; $display("FAIL run_write_no_rdata got %h want 00", f_rdata); end
      @(negedge clk);
      f_cs = 1'b0;
      #1;
      checks++; if (f_rdata !== 8'h5A) begin errors++; $display("FAIL run_readback got %h want 5a", f_rdata); end
      f_cs = 1'b1; f_we = 1'b1; f_addr = 6'd41; f_wdata = 8'h33;
      @(negedge clk);
      f_cs = 1'b0; f_we = 1'b0;
      #1;
      checks++; if (f_rdata !== 8'h5A) begin errors++; $display("FAIL run_rdata_hold got %h want 5a", f_rdata); end
      f_cs = 1'b1; f_addr = 6'd3;
      @(negedge clk);
      f_cs = 1'b0;
      #1;
      checks++; if (f_rdata !== pix_val(3, seed)) begin errors++; $display("FAIL run_bank0_read got %h want %h", f_rdata, pix_val(3, seed)); end
   endtask

   task automatic test_drain(input string tag, input int period);
      int k = 0, cyc = 0, first = -1, last_cyc = 0;
      bit   stalled = 1'b0;
      logic [7:0] held = 8'h00;
      while (k < N && cyc < 2000) begin
         m_ready = ((cyc % period) == 0);
         #1;
         if (stalled) begin
            checks++; if (m_valid !== 1'b1 || m_data !== held) begin
               errors++; $display("FAIL %s_stable k=%0d got v=%b d=%h want v=1 d=%h", tag, k, m_valid, m_data, held); end
         end
         stalled = 1'b0;
         if (m_valid) begin
            if (first < 0) first = cyc;
            checks++; if (m_data !== exp_out[k]) begin errors++; $display("FAIL %s_data k=%0d got %h want %h", tag, k, m_data, exp_out[k]); end
            checks++; if (m_last !== (k == N - 1)) begin errors++; $display("FAIL %s_last k=%0d got %b want %b", tag, k, m_last, (k == N - 1)); end
            if (m_ready) begin
               k++;
               last_cyc = cyc;
            end else begin
               stalled = 1'b1;
               held    = m_data;
            end
         end
         @(negedge clk);
         cyc++;
      end
      m_ready = 1'b0;
      checks++; if (k != N) begin errors++; $display("FAIL %s_timeout got %0d bytes want %0d", tag, k, N); end
      if (period == 1) begin
         checks++; if (first < 0 || first > 3) begin errors++; $display("FAIL %s_first_latency got %0d want <=3", tag, first); end
         checks++; if (last_cyc - first != N - 1) begin errors++; $display("FAIL %s_throughput got %0d want %0d", tag, last_cyc - first, N - 1); end
      end
      #1;
      checks++; if ({done, busy, m_valid} !== 3'b110) begin errors++; $display("FAIL %s_done got %b want 110", tag, {done, busy, m_valid}); end
      @(negedge clk); #1;
      checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL %s_idle got %b want 00", tag, {done, busy}); end
   endtask

   task automatic test_idle_access(input logic [7:0] held);
      f_cs = 1'b1; f_we = 1'b1; f_addr = 6'd33; f_wdata = 8'hEE;
      @(negedge clk);
      f_we = 1'b0;
      @(negedge clk);
      f_cs = 1'b0; f_finish = 1'b1;
      #1;
      checks++; if (f_rdata !== held) begin errors++; $display("FAIL idle_rdata got %h want %h", f_rdata, held); end
      @(negedge clk);
      f_finish = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_finish_ignored got %b want 0", busy); end
   endtask

   // Second job right after the first: engine leaves bank 1 alone, so job-1 results stream again.
   task automatic test_back_to_back();
      do_go();
      send_coefs();
      send_pixels(N, 9);
      @(negedge clk);
      @(negedge clk);
      finish_pulse();
      test_drain("bp", 3);
   endtask

   task automatic test_abort();
      do_go();
      send_coefs();
      send_pixels(10, 9);
      rst = 1'b1;
      #1;
      checks++; if ({busy, s_ready, h_write, f_start} !== 4'b0000) begin errors++; $display("FAIL abort_ctrl got %b want 0000", {busy, s_ready, h_write, f_start}); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #1;
      checks++; if ({busy, s_ready, m_valid, done} !== 4'b0000) begin errors++; $display("FAIL abort_idle got %b want 0000", {busy, s_ready, m_valid, done}); end
      checks++; if (f_rdata !== 8'h00) begin errors++; $display("FAIL abort_rdata got %h want 00", f_rdata); end
      do_go();
      send_coefs();
      test_load(11);
      f_cs = 1'b1; f_addr = 6'd12;
      @(negedge clk);
      f_cs = 1'b0;
      #1;
      checks++; if (f_rdata !== pix_val(12, 11)) begin errors++; $display("FAIL abort_reload got %h want %h", f_rdata, pix_val(12, 11)); end
      engine_fill(11);
      finish_pulse();
      test_drain("rejob", 1);
   endtask

   initial begin
      test_reset();
      test_coeffs();
      test_load(5);
      test_run_ram(5);
      engine_fill(5);
      finish_pulse();
      test_drain("drain", 1);
      test_idle_access(pix_val(3, 5));
      test_back_to_back();
      test_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
